// File: rtl/necesidades_pkg.sv
// Shared definitions for the multi-need pet state machine: condition encoding,
// a width helper and default parameter values.
package necesidades_pkg;

    // Overall pet condition, as driven on Estado
    typedef enum logic [1:0] {
        FELIZ     = 2'b00,
        NECESIDAD = 2'b01,
        CRITICO   = 2'b10,
        MUERTO    = 2'b11
    } estado_t;

    // Default parameter values
    localparam int unsigned DEF_NUM_NEC         = 3;
    localparam int unsigned DEF_NIVEL_W         = 2;
    localparam int unsigned DEF_DECAY_TICKS     = 1000;
    localparam int unsigned DEF_UMBRAL          = 1;
    localparam int unsigned DEF_FEED_STEP       = 1;
    localparam int unsigned DEF_DEATH_TICKS     = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

    // Ceiling log2, never below 1 so it can size a vector directly
    function automatic int unsigned clog2(input int unsigned valor);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(valor)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// Per-button conditioner: 2-FF synchroniser followed by a stability counter.
// The output only follows the input after DEBOUNCE_CYCLES consecutive cycles
// of a changed synchronised value. Used only when DEBOUNCE_EN is defined.
module antirrebote
    import necesidades_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic salida_estable
);

    localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cuenta;

    // Synchronise, then accept a new level once it has been stable long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a         <= 1'b0;
            sync_b         <= 1'b0;
            cuenta         <= '0;
            salida_estable <= 1'b0;
        end else begin
            sync_a <= entrada;
            sync_b <= sync_a;
            if (sync_b == salida_estable) begin
                cuenta <= '0;
            end else if (cuenta == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                salida_estable <= sync_b;
                cuenta         <= '0;
            end else begin
                cuenta <= cuenta + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/maquina_necesidades_n.sv
// Multi-need pet state machine: NUM_NEC levels decay on a shared prescaler and
// are replenished by per-need buttons; a registered FSM reports condition and
// the most urgent need. Optional macro DEBOUNCE_EN inserts an antirrebote
// conditioner per button; otherwise a single register stage feeds edge detect.
module maquina_necesidades_n
    import necesidades_pkg::*;
#(
    parameter int unsigned NUM_NEC         = DEF_NUM_NEC,
    parameter int unsigned NIVEL_W         = DEF_NIVEL_W,
    parameter int unsigned DECAY_TICKS     = DEF_DECAY_TICKS,
    parameter int unsigned UMBRAL          = DEF_UMBRAL,
    parameter int unsigned FEED_STEP       = DEF_FEED_STEP,
    parameter int unsigned DEATH_TICKS     = DEF_DEATH_TICKS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    localparam int unsigned IDX_W          = clog2(NUM_NEC)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_NEC-1:0]         Botones,
    output logic [NUM_NEC*NIVEL_W-1:0] Niveles,
    output logic [1:0]                 Estado,
    output logic [IDX_W-1:0]           Necesidad,
    output logic                       Paso_Decay
);

    localparam int unsigned MAX   = (2 ** NIVEL_W) - 1;
    localparam int unsigned SUM_W = NIVEL_W + 1;
    localparam int unsigned PRE_W = clog2(DECAY_TICKS);
    localparam int unsigned DTH_W = clog2(DEATH_TICKS + 1);

    // Reject configurations outside the supported range
    if (NUM_NEC < 2 || NUM_NEC > 8 || DECAY_TICKS < 2 || UMBRAL >= MAX ||
        FEED_STEP < 1 || FEED_STEP > MAX || DEBOUNCE_CYCLES < 1) begin : g_param_err
        $error("maquina_necesidades_n: unsupported parameter set");
    end

    logic [PRE_W-1:0]                prescaler;
    logic [NUM_NEC-1:0]              acondicionado;
    logic [NUM_NEC-1:0]              btn_q;
    logic [NUM_NEC-1:0]              btn_prev;
    logic                            btn_vld;
    logic                            prev_vld;
    logic [NUM_NEC-1:0]              pulsos_c;
    logic [NUM_NEC-1:0][NIVEL_W-1:0] nivel;
    logic [NUM_NEC-1:0][NIVEL_W-1:0] nivel_next;
    logic [SUM_W-1:0]                suma;
    logic                            hay_cero;
    logic                            hay_bajo;
    logic [NIVEL_W-1:0]              min_val;
    logic [IDX_W-1:0]                min_idx;
    estado_t                         estado;
    estado_t                         estado_next;
    estado_t                         clase;
    logic [IDX_W-1:0]                nec_next;
    logic [DTH_W-1:0]                muerte;
    logic [DTH_W-1:0]                muerte_next;
    logic                            muerto;

    assign Niveles = nivel;
    assign Estado  = estado;
    assign muerto  = (estado == MUERTO);

    // Prescaler; Paso_Decay is registered so it is high while the count sits at DECAY_TICKS-1
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            Paso_Decay <= 1'b0;
        end else begin
            prescaler  <= (prescaler == PRE_W'(DECAY_TICKS - 1)) ? '0 : prescaler + PRE_W'(1);
            Paso_Decay <= (prescaler == PRE_W'(DECAY_TICKS - 2));
        end
    end

`ifdef DEBOUNCE_EN
    for (genvar k = 0; k < NUM_NEC; k++) begin : g_antirrebote
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_antirrebote (
            .clk           (clk),
            .reset         (reset),
            .entrada       (Botones[k]),
            .salida_estable(acondicionado[k])
        );
    end
`else
    assign acondicionado = Botones;
`endif

    // Button sample and edge history; the valid flags keep a button held through reset from counting
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q    <= '0;
            btn_prev <= '0;
            btn_vld  <= 1'b0;
            prev_vld <= 1'b0;
        end else begin
            btn_q    <= acondicionado;
            btn_prev <= btn_q;
            btn_vld  <= 1'b1;
            prev_vld <= btn_vld;
        end
    end

    assign pulsos_c = btn_q & ~btn_prev & {NUM_NEC{prev_vld}};

    // Next level per need: add the press, then the decay, then clamp to MAX
    always_comb begin
        nivel_next = nivel;
        suma       = '0;
        for (int unsigned k = 0; k < NUM_NEC; k++) begin
            suma = SUM_W'(nivel[k]);
            if (pulsos_c[k] && !muerto) suma = suma + SUM_W'(FEED_STEP);
            if (Paso_Decay && !muerto && (suma != '0)) suma = suma - SUM_W'(1);
            nivel_next[k] = (suma > SUM_W'(MAX)) ? NIVEL_W'(MAX) : suma[NIVEL_W-1:0];
        end
    end

    // Level array
    always_ff @(posedge clk) begin
        if (reset) nivel <= {NUM_NEC{NIVEL_W'(MAX)}};
        else       nivel <= nivel_next;
    end

    // Classify levels and find the lowest one (ties resolve to the lower index)
    always_comb begin
        hay_cero = 1'b0;
        hay_bajo = 1'b0;
        min_val  = nivel[0];
        min_idx  = '0;
        for (int unsigned k = 0; k < NUM_NEC; k++) begin
            if (nivel[k] == '0) hay_cero = 1'b1;
            if (nivel[k] <= NIVEL_W'(UMBRAL)) hay_bajo = 1'b1;
            if (nivel[k] < min_val) begin
                min_val = nivel[k];
                min_idx = IDX_W'(k);
            end
        end
    end

    // FSM state, death counter and urgent-need registers
    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= FELIZ;
            muerte    <= '0;
            Necesidad <= '0;
        end else begin
            estado    <= estado_next;
            muerte    <= muerte_next;
            Necesidad <= nec_next;
        end
    end

    // Next condition, death count and urgent need; MUERTO holds everything
    always_comb begin
        estado_next = estado;
        muerte_next = '0;
        nec_next    = Necesidad;
        clase       = hay_cero ? CRITICO : (hay_bajo ? NECESIDAD : FELIZ);
        case (estado)
            MUERTO:  estado_next = MUERTO;
            CRITICO: estado_next = (muerte == DTH_W'(DEATH_TICKS)) ? MUERTO : clase;
            default: estado_next = clase;
        endcase
        if (estado == CRITICO) begin
            muerte_next = muerte;
            if (Paso_Decay && (muerte != DTH_W'(DEATH_TICKS))) muerte_next = muerte + DTH_W'(1);
        end
        if (estado != MUERTO) nec_next = (estado_next == FELIZ) ? '0 : min_idx;
    end

endmodule

// File: tb/tb_maquina_necesidades_n.sv
// Self-checking bench for maquina_necesidades_n (DEBOUNCE_EN undefined).
// A cycle model of the pet rules is checked against the DUT on every edge;
// directed scenarios add hand-computed literal checks at key points.
module tb_maquina_necesidades_n;

    localparam int DT   = 8;
    localparam int DTH  = 2;
    localparam int UM   = 1;
    localparam int FS   = 1;
    localparam int MAXL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] Botones = 3'b000;
    logic [5:0] Niveles;
    logic [1:0] Estado;
    logic [1:0] Necesidad;
    logic       Paso_Decay;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    maquina_necesidades_n #(
        .NUM_NEC        (3),
        .NIVEL_W        (2),
        .DECAY_TICKS    (DT),
        .UMBRAL         (UM),
        .FEED_STEP      (FS),
        .DEATH_TICKS    (DTH),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Botones   (Botones),
        .Niveles   (Niveles),
        .Estado    (Estado),
        .Necesidad (Necesidad),
        .Paso_Decay(Paso_Decay)
    );

    task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        n_tests++;
        if (actual !== esperado) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nombre, $time, actual, esperado);
        end
    endtask

    // Behavioural model: levels as integers, condition as 0..3
    int         m_lvl [3];
    int         m_est, m_nec, m_death, m_t;
    logic [2:0] m_pend, m_prev;
    bit         m_have;

    always @(posedge clk) begin : modelo
        int  n_lvl [3];
        int  s, cls, n_est, n_nec, n_death, mn, mi, pack;
        bit  paso_now, dead, any0, anylow;
        if (reset) begin
            for (int k = 0; k < 3; k++) m_lvl[k] = MAXL;
            m_est = 0; m_nec = 0; m_death = 0; m_t = 0;
            m_pend = 3'b000; m_prev = 3'b000; m_have = 1'b0;
        end else begin
            paso_now = (m_t == DT - 1);
            dead     = (m_est == 3);
            any0 = 0; anylow = 0; mn = MAXL + 1; mi = 0;
            for (int k = 0; k < 3; k++) begin
                s = m_lvl[k];
                if (!dead && m_pend[k]) s = s + FS;
                if (!dead && paso_now && s > 0) s = s - 1;
                n_lvl[k] = (s > MAXL) ? MAXL : s;
                if (m_lvl[k] == 0) any0 = 1;
                if (m_lvl[k] <= UM) anylow = 1;
                if (m_lvl[k] < mn) begin mn = m_lvl[k]; mi = k; end
            end
            cls = any0 ? 2 : (anylow ? 1 : 0);
            if (dead)                              n_est = 3;
            else if (m_est == 2 && m_death >= DTH) n_est = 3;
            else                                   n_est = cls;
            if (dead)             n_nec = m_nec;
            else if (n_est == 0)  n_nec = 0;
            else                  n_nec = mi;
            if (m_est == 2) n_death = (paso_now && m_death < DTH) ? m_death + 1 : m_death;
            else            n_death = 0;
            for (int k = 0; k < 3; k++) m_lvl[k] = n_lvl[k];
            m_est = n_est; m_nec = n_nec; m_death = n_death;
            m_t = (m_t + 1) % DT;
            m_pend = Botones & ~m_prev & {3{m_have}};
            m_prev = Botones;
            m_have = 1'b1;
        end
        pack = m_lvl[0] + m_lvl[1] * 4 + m_lvl[2] * 16;
        #1;
        chk("model_niveles", 32'(Niveles), 32'(pack));
        chk("model_estado", 32'(Estado), 32'(m_est));
        chk("model_necesidad", 32'(Necesidad), 32'(m_nec));
        chk("model_paso", 32'(Paso_Decay), 32'(m_t == DT - 1));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v);
        @(negedge clk);
        Botones = v;
    endtask

    task automatic check_reset_values();
        chk("rst_niveles", 32'(Niveles), 32'd63);
        chk("rst_estado", 32'(Estado), 32'd0);
        chk("rst_necesidad", 32'(Necesidad), 32'd0);
        chk("rst_paso", 32'(Paso_Decay), 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Power-on reset held 3 cycles
        do_reset(3);

        // Free decay: steps land at R8, R16, R24; condition lags by one edge
        step(17);
        chk("decay2_niveles", 32'(Niveles), 32'd21);
        chk("decay2_estado", 32'(Estado), 32'd1);
        chk("decay2_necesidad", 32'(Necesidad), 32'd0);
        step(8);
        chk("decay3_niveles", 32'(Niveles), 32'd0);
        chk("decay3_estado", 32'(Estado), 32'd2);
        step(15);
        chk("pre_death_estado", 32'(Estado), 32'd2);
        step(1);
        chk("death_estado", 32'(Estado), 32'd3);

        // Presses in MUERTO are ignored and the state is absorbing
        drive(3'b111);
        step(5);
        drive(3'b000);
        step(20);
        chk("dead_niveles", 32'(Niveles), 32'd0);
        chk("dead_estado", 32'(Estado), 32'd3);
        chk("dead_necesidad", 32'(Necesidad), 32'd0);

        // Reset out of MUERTO with need 0 held through release
        drive(3'b001);
        do_reset(2);
        step(14);
        chk("held_reset_niveles", 32'(Niveles), 32'd42);

        // Need 2 edge lands in the decay cycle at level 2: stays 2
        drive(3'b100);
        step(2);
        chk("coincident_niveles", 32'(Niveles), 32'd37);

        // Need 1 held 20 cycles from level 1: one increment only
        drive(3'b010);
        step(2);
        chk("held_first_niveles", 32'(Niveles), 32'd41);
        step(4);
        chk("held_later_niveles", 32'(Niveles), 32'd41);
        step(14);
        drive(3'b000);

        // Mid-run reset
        do_reset(1);

        // Press at level 3 saturates
        step(1);
        drive(3'b001);
        step(1);
        drive(3'b000);
        step(1);
        chk("saturate_niveles", 32'(Niveles), 32'd63);

        // Priority: {2,1,1} -> need 1, then feed need 1 -> need 2
        step(13);
        drive(3'b001);
        step(1);
        drive(3'b000);
        step(2);
        chk("prio1_niveles", 32'(Niveles), 32'd22);
        chk("prio1_estado", 32'(Estado), 32'd1);
        chk("prio1_necesidad", 32'(Necesidad), 32'd1);
        drive(3'b010);
        step(1);
        drive(3'b000);
        step(2);
        chk("prio2_niveles", 32'(Niveles), 32'd26);
        chk("prio2_estado", 32'(Estado), 32'd1);
        chk("prio2_necesidad", 32'(Necesidad), 32'd2);

        step(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/maquina_necesidades_n.md
# maquina_necesidades_n

Parametrised successor of the single-need pet state machine: tracks NUM_NEC independent need levels (food, sleep, play, …) that decay on a shared prescaled timer and are replenished by per-need buttons. A registered FSM classifies overall pet condition, reports the most urgent need, and latches a terminal death state. It sits between the button front end and the display/sprite selector.

## Interface
- NUM_NEC, 3: number of needs; must be 2..8.
- NIVEL_W, 2: level width; MAX = 2^NIVEL_W-1.
- DECAY_TICKS, 1000: clock cycles per decay step; must be 2 or more.
- UMBRAL, 1: a level <= UMBRAL counts as "needy"; must be less than MAX.
- FEED_STEP, 1: increment per accepted press; must be 1..MAX.
- DEATH_TICKS, 4: consecutive decay steps spent in CRITICO before MUERTO.
- DEBOUNCE_CYCLES, 16: stability window; only used with DEBOUNCE_EN.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; overrides all other inputs.
- Botones  in  NUM_NEC  raw per-need buttons, level-sensitive, bit k = need k.
- Niveles  out  NUM_NEC*NIVEL_W  packed levels, need k at [k*NIVEL_W +: NIVEL_W]; reset all MAX.
- Estado  out  2  00 FELIZ, 01 NECESIDAD, 10 CRITICO, 11 MUERTO; reset 00.
- Necesidad  out  clog2(NUM_NEC)  index of most urgent need; reset 0.
- Paso_Decay  out  1  one-cycle pulse on each decay step; reset 0.

## Operation
- Prescaler counts 0..DECAY_TICKS-1 and wraps. Paso_Decay=1 in the cycle the count equals DECAY_TICKS-1.
- On that cycle every level with a value above 0 decrements by 1. Levels saturate at 0.
- Each button is conditioned, then rising-edge detected. Each accepted edge adds FEED_STEP, saturating at MAX.
- Holding a button high gives exactly one increment.
- Press and decay in the same cycle on the same need: new level = clamp(L + FEED_STEP - 1, 0, MAX), computed at NIVEL_W+1 bits.
- Buttons on different needs in the same cycle are all applied independently.
- FSM, registered, evaluated from current Niveles:
  - FELIZ: all levels > UMBRAL.
  - NECESIDAD: some level <= UMBRAL and no level is 0.
  - CRITICO: some level is 0.
  - MUERTO: entered from CRITICO when the death counter reaches DEATH_TICKS. Absorbing; only reset leaves it.
- Transitions between FELIZ, NECESIDAD and CRITICO follow the levels directly, in any direction.
- Death counter:
  - Increments on each Paso_Decay while in CRITICO.
  - Clears whenever the state is not CRITICO.
  - Saturates at DEATH_TICKS.
- In MUERTO: button edges are ignored, levels freeze, and the prescaler keeps running.
- Necesidad:
  - FELIZ: 0.
  - NECESIDAD / CRITICO: index of the lowest level; ties go to the lowest index.
  - MUERTO: value frozen at entry.

## Timing
- Level update lands on the clock edge of the Paso_Decay cycle.
- Estado and Necesidad lag Niveles by exactly 1 cycle.
- Press latency without DEBOUNCE_EN: Botones rises before edge E0, is sampled at E0, and Niveles changes at edge E1.
- Press latency with DEBOUNCE_EN: 2-FF synchroniser, then DEBOUNCE_CYCLES of stable input, then edge detect. Niveles changes DEBOUNCE_CYCLES+3 edges after the raw rise.
- Glitches shorter than DEBOUNCE_CYCLES produce no change.
- Reset asserted mid-operation:
  - Next edge: levels return to MAX, prescaler and death counter clear, Estado=FELIZ, Necesidad=0, Paso_Decay=0.
  - Conditioner and edge registers clear, so a button already held at reset release does not count until it is released and pressed again.

## Configuration
- DEBOUNCE_EN defined: each button passes through the `antirrebote` sub-module (synchroniser plus stability counter of clog2(DEBOUNCE_CYCLES+1) bits).
- DEBOUNCE_EN undefined: single register stage plus edge detect; DEBOUNCE_CYCLES is unused.

## Structure
- Shared package `necesidades_pkg`:
  - Estado encoding localparams: FELIZ, NECESIDAD, CRITICO, MUERTO.
  - clog2 helper function.
  - Default parameter constants.
- Sub-module `antirrebote`:
  - One instance per button, via generate loop.
  - Ports: clk, reset, entrada, salida_estable.
  - Edge detection stays in the top level.
- Top level holds the prescaler, level array, death counter, FSM, and the min-index priority tree.

## Test plan
All scenarios use NUM_NEC=3, NIVEL_W=2, DECAY_TICKS=8, UMBRAL=1, DEATH_TICKS=2, FEED_STEP=1, DEBOUNCE_EN off.
- Reset: hold reset 3 cycles -> Niveles all 3, Estado=00, Necesidad=0, Paso_Decay=0. Reset is also asserted mid-run and must give the same values one edge later.
- Free decay, no presses:
  - After 2nd Paso_Decay: levels 1, Estado=01, Necesidad=0.
  - After 3rd: levels 0, Estado=10.
  - After 5th: Estado=11 and stays there.
- Held button: Botones[1] high for 20 cycles starting from level 1 -> level 2 exactly once, at the edge after sampling.
- Coincident press and decay: Botones[2] edge accepted in the Paso_Decay cycle at level 2 -> level stays 2. Separately, a press at level 3 leaves the level at 3 (saturation).
- Priority: levels {2,1,1} -> Necesidad=1. Then feed need 1 -> Necesidad=2.
- Death: in MUERTO, press all buttons -> Niveles unchanged, Estado=11. Then assert reset -> FELIZ, levels 3.
